thread_fetch: RTL
=================

Name: thread_fetch

Overview:
- Per-thread fetch stage directly downstream of the thread scheduler.
- Holds one PC per hardware thread and issues instruction-memory requests for the thread selected each cycle.
- Tracks one in-flight fetch per thread, misses and squashes, and hands fetched instructions to decode.
- Drives the per-thread stalled vector back to the scheduler.

Parameters:
- N_THREADS, 8, thread count; equals n_threads from common; thread ids are threadid_t (3 bits).
- PC_W, 32, PC and address width.
- RESET_PC, 32'h0000_1000, PC of every thread after reset.
- EXC_VECTOR, 32'h0000_2000, PC loaded on exception redirect.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- thread  in  3  thread selected by the scheduler this cycle.
- stalled  out  N_THREADS  per-thread stall to the scheduler; stalled[i] = inflight[i] | miss_wait[i].
- imem_req_valid  out  1  request valid (registered).
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  PC_W  fetch address.
- imem_req_thread  out  3  requesting thread.
- imem_rsp_valid  in  1  response valid; at most one per cycle; arrives at least 1 cycle after acceptance; may be out of order across threads.
- imem_rsp_thread  in  3  thread of the response.
- imem_rsp_miss  in  1  1 = miss, data invalid.
- imem_rsp_data  in  32  instruction word.
- imem_fill_valid  in  1  line fill complete.
- imem_fill_thread  in  3  thread whose miss is filled.
- br_en, br_thread, br_target  in  1/3/PC_W  branch redirect.
- exc_en, exc_thread  in  1/3  exception redirect to EXC_VECTOR.
- dec_valid  out  1  instruction to decode (registered).
- dec_thread  out  3  thread of the instruction.
- dec_pc  out  PC_W  PC of the instruction.
- dec_instr  out  32  instruction word.

Behaviour:
- Reset: pc[*]=RESET_PC; inflight, miss_wait, squash = 0; imem_req_valid=0; dec_valid=0; dec_thread/dec_pc/dec_instr=0; stalled=0. Reset mid-operation drops all outstanding state. Responses and fills that arrive after reset are ignored because inflight and miss_wait are 0.
- Issue: on a cycle where (!imem_req_valid | imem_req_ready) and !stalled[thread]:
  - register req_valid=1, addr=pc[thread], req_thread=thread;
  - set inflight[thread].
  - Otherwise the scheduler slot is lost; there is no backpressure to the scheduler.
- Hold: while imem_req_valid & !imem_req_ready, the request fields stay stable. The request is dropped at the next edge after the handshake unless a new issue occurs.
- PC is not incremented at issue. On a hit response for thread T that is not squashed:
  - pc[T] += 4, wrapping modulo 2^PC_W;
  - dec_valid=1 next cycle with T, the old pc[T] and data;
  - clear inflight[T].
- Miss response for T that is not squashed: clear inflight[T], set miss_wait[T], pc unchanged, no dec_valid.
- Fill: imem_fill_valid with miss_wait[thread] set clears that bit. A fill for a thread without miss_wait is ignored.
- Redirect (br_en, or exc_en with target EXC_VECTOR):
  - pc[T] = target next cycle;
  - if inflight[T], set squash[T]; the matching response only clears inflight[T] and squash[T] (no decode, no miss_wait);
  - miss_wait[T] is not cleared; the thread refetches from the new PC after the fill.
  - If the request for T is still pending (valid & !ready), it is also covered by squash.
- Simultaneous events:
  - exc_en and br_en on the same thread: exc wins.
  - Different threads: both apply.
  - Redirect and response for T in the same cycle: redirect wins, the response is discarded, inflight[T] is cleared.
  - Fill and miss for different threads in the same cycle: both apply.
- dec_valid is a single-cycle pulse per hit. Decode never backpressures.

Optional Feature:
- Macro THREAD_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch (32, hit count), perf_miss (32, non-squashed misses) and perf_squash (32, discarded responses). All reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, thread=0, ready=1, hit with data 32'hDEAD_BEEF two cycles later -> req addr 32'h1000 thread 0. Next: dec_valid=1, dec_pc=32'h1000, dec_instr=32'hDEAD_BEEF, pc[0]=32'h1004, stalled[0] rises then falls.
- Thread 3 miss -> stalled[3]=1 until fill thread 3. Next selection of 3 refetches 32'h1000. A fill for thread 5 alone has no effect.
- Hold ready=0 for 4 cycles with thread 2 pending -> req_addr/req_thread stable. Other scheduler slots are dropped; only one request is accepted.
- br_en thread 1 target 32'h4000 while thread 1 is in flight -> the hit response produces no dec_valid. Next fetch of thread 1 uses 32'h4000.
- exc_en and br_en both on thread 6 in the same cycle -> pc[6]=32'h2000.
- Reset asserted with threads 0/4 in flight, then their responses arrive -> no dec_valid, stalled=0, all PCs 32'h1000. With THREAD_FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/thread_fetch_if.sv
// rtl/thread_fetch_if.sv - instruction-memory request/response/fill bundle between fetch and imem
interface thread_fetch_if #(
  parameter int unsigned PC_W = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic [2:0]      imem_req_thread;
  logic            imem_rsp_valid;
  logic [2:0]      imem_rsp_thread;
  logic            imem_rsp_miss;
  logic [31:0]     imem_rsp_data;
  logic            imem_fill_valid;
  logic [2:0]      imem_fill_thread;

  modport master (
    output imem_req_valid, imem_req_addr, imem_req_thread,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_thread, imem_rsp_miss, imem_rsp_data,
    input  imem_fill_valid, imem_fill_thread
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_req_thread,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_thread, imem_rsp_miss, imem_rsp_data,
    output imem_fill_valid, imem_fill_thread
  );
endinterface

// File: rtl/thread_fetch.sv
// rtl/thread_fetch.sv - per-thread fetch stage; THREAD_FETCH_PERF_EN adds perf_fetch/perf_miss/perf_squash counters
module thread_fetch #(
  parameter int unsigned     N_THREADS  = 8,
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_1000,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           thread,
  output logic [N_THREADS-1:0] stalled,
  thread_fetch_if.master       imem,
  input  logic                 br_en,
  input  logic [2:0]           br_thread,
  input  logic [PC_W-1:0]      br_target,
  input  logic                 exc_en,
  input  logic [2:0]           exc_thread,
  output logic                 dec_valid,
  output logic [2:0]           dec_thread,
  output logic [PC_W-1:0]      dec_pc,
  output logic [31:0]          dec_instr
`ifdef THREAD_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch,
  output logic [31:0]          perf_miss,
  output logic [31:0]          perf_squash
`endif
);

  logic [PC_W-1:0]      pc_q [N_THREADS];
  logic [PC_W-1:0]      pc_d [N_THREADS];
  logic [N_THREADS-1:0] inflight_q, inflight_d;
  logic [N_THREADS-1:0] miss_wait_q, miss_wait_d;
  logic [N_THREADS-1:0] squash_q, squash_d;
  logic                 req_valid_q, req_valid_d;
  logic [PC_W-1:0]      req_addr_q, req_addr_d;
  logic [2:0]           req_thread_q, req_thread_d;
  logic                 dec_valid_q, dec_valid_d;
  logic [2:0]           dec_thread_q, dec_thread_d;
  logic [PC_W-1:0]      dec_pc_q, dec_pc_d;
  logic [31:0]          dec_instr_q, dec_instr_d;

  logic       issue;
  logic       rsp_live;
  logic       rsp_redir;
  logic       rsp_drop;
  logic       rsp_hit;
  logic       rsp_miss_ok;
  logic       br_apply;
  logic [2:0] rt;

  assign stalled = inflight_q | miss_wait_q;

  // A response only counts if its thread still has a fetch outstanding;
  // this is what makes stale responses after reset or squash harmless.
  assign rt          = imem.imem_rsp_thread;
  assign rsp_live    = imem.imem_rsp_valid && inflight_q[rt];
  assign rsp_redir   = (exc_en && exc_thread == rt) || (br_en && br_thread == rt);
  assign rsp_drop    = rsp_live && (rsp_redir || squash_q[rt]);
  assign rsp_hit     = rsp_live && !rsp_drop && !imem.imem_rsp_miss;
  assign rsp_miss_ok = rsp_live && !rsp_drop && imem.imem_rsp_miss;
  assign br_apply    = br_en && !(exc_en && exc_thread == br_thread);
  assign issue       = (!req_valid_q || imem.imem_req_ready) && !stalled[thread];

  // Next state: issue, then response, then fill, then redirects (redirects win on pc)
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    miss_wait_d  = miss_wait_q;
    squash_d     = squash_q;
    req_valid_d  = req_valid_q && !imem.imem_req_ready;
    req_addr_d   = req_addr_q;
    req_thread_d = req_thread_q;
    dec_valid_d  = 1'b0;
    dec_thread_d = dec_thread_q;
    dec_pc_d     = dec_pc_q;
    dec_instr_d  = dec_instr_q;

    if (issue) begin
      req_valid_d        = 1'b1;
      req_addr_d         = pc_q[thread];
      req_thread_d       = thread;
      inflight_d[thread] = 1'b1;
    end

    if (rsp_live) begin
      inflight_d[rt] = 1'b0;
      squash_d[rt]   = 1'b0;
    end
    if (rsp_miss_ok) begin
      miss_wait_d[rt] = 1'b1;
    end
    if (rsp_hit) begin
      pc_d[rt]     = pc_q[rt] + PC_W'(4);
      dec_valid_d  = 1'b1;
      dec_thread_d = rt;
      dec_pc_d     = pc_q[rt];
      dec_instr_d  = imem.imem_rsp_data;
    end

    if (imem.imem_fill_valid && miss_wait_q[imem.imem_fill_thread]) begin
      miss_wait_d[imem.imem_fill_thread] = 1'b0;
    end

    // Anything still outstanding for a redirected thread (including a request
    // issued this very cycle) is fetching from the old path and gets squashed.
    if (exc_en) begin
      pc_d[exc_thread] = EXC_VECTOR;
      if (inflight_d[exc_thread]) squash_d[exc_thread] = 1'b1;
    end
    if (br_apply) begin
      pc_d[br_thread] = br_target;
      if (inflight_d[br_thread]) squash_d[br_thread] = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_THREADS; i++) pc_q[i] <= RESET_PC;
      inflight_q   <= '0;
      miss_wait_q  <= '0;
      squash_q     <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_thread_q <= '0;
      dec_valid_q  <= 1'b0;
      dec_thread_q <= '0;
      dec_pc_q     <= '0;
      dec_instr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      miss_wait_q  <= miss_wait_d;
      squash_q     <= squash_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_thread_q <= req_thread_d;
      dec_valid_q  <= dec_valid_d;
      dec_thread_q <= dec_thread_d;
      dec_pc_q     <= dec_pc_d;
      dec_instr_q  <= dec_instr_d;
    end
  end

  assign imem.imem_req_valid  = req_valid_q;
  assign imem.imem_req_addr   = req_addr_q;
  assign imem.imem_req_thread = req_thread_q;
  assign dec_valid            = dec_valid_q;
  assign dec_thread           = dec_thread_q;
  assign dec_pc               = dec_pc_q;
  assign dec_instr            = dec_instr_q;

`ifdef THREAD_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_miss_q, perf_miss_d;
  logic [31:0] perf_squash_q, perf_squash_d;

  // Count hits, accepted misses and discarded responses; wrap naturally
  always_comb begin
    perf_fetch_d  = perf_fetch_q + 32'(rsp_hit);
    perf_miss_d   = perf_miss_q + 32'(rsp_miss_ok);
    perf_squash_d = perf_squash_q + 32'(rsp_drop);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_miss_q   <= '0;
      perf_squash_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_miss_q   <= perf_miss_d;
      perf_squash_q <= perf_squash_d;
    end
  end

  assign perf_fetch  = perf_fetch_q;
  assign perf_miss   = perf_miss_q;
  assign perf_squash = perf_squash_q;
`endif

endmodule
